// File: rtl/lvds_tx_pkg.sv
// Shared constants, state encoding and frame builder for the LVDS TX serializer.
// A frame is two 16-bit halves: sync pair followed by a left-justified sample field.
package lvds_tx_pkg;

  localparam int FRAME_BITS = 32;
  localparam int HALF_BITS  = FRAME_BITS / 2;
  localparam int FIELD_BITS = HALF_BITS - 2;
  localparam int CNT_W      = 4;

  localparam logic [1:0]       SYNC_I   = 2'b10;
  localparam logic [1:0]       SYNC_Q   = 2'b01;
  localparam logic [CNT_W-1:0] CNT_PULL = 4'd14;
  localparam logic [CNT_W-1:0] CNT_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [FIELD_BITS-1:0] i_field,
    input logic [FIELD_BITS-1:0] q_field
  );
    return {SYNC_I, i_field, SYNC_Q, q_field};
  endfunction

endpackage

// File: rtl/lvds_tx.sv
// LVDS TX framer/serializer: pulls IQ words from the TX FIFO, frames them and
// shifts the frame out two bits per clock into the DDR output register.
module lvds_tx
  import lvds_tx_pkg::*;
#(
  parameter int IQ_WIDTH = 13,
  parameter int I_LSB    = 16,
  parameter int Q_LSB    = 0
) (
  input  logic        i_ddr_clk,
  input  logic        i_reset,
  input  logic        i_tx_enable,
  input  logic        i_clear_underrun,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_pull,
  output logic [1:0]  o_ddr_data,
  output logic        o_busy,
  output logic        o_underrun
);

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   underrun_q, underrun_d;
  logic                   pull;
  logic                   can_pull;

  logic [IQ_WIDTH-1:0]    i_smp, q_smp;
  logic [FIELD_BITS-1:0]  i_field, q_field;
  logic [FRAME_BITS-1:0]  frame;
  logic                   unused_data;

  // Samples are left-justified in their 14-bit field; low bits become the pad.
  assign i_smp   = i_fifo_data[I_LSB +: IQ_WIDTH];
  assign q_smp   = i_fifo_data[Q_LSB +: IQ_WIDTH];
  assign i_field = FIELD_BITS'(i_smp) << (FIELD_BITS - IQ_WIDTH);
  assign q_field = FIELD_BITS'(q_smp) << (FIELD_BITS - IQ_WIDTH);
  assign frame   = build_frame(i_field, q_field);

  assign unused_data = ^i_fifo_data;
  assign can_pull    = i_tx_enable && !i_fifo_empty;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    underrun_d = underrun_q;
    pull       = 1'b0;

    case (state_q)
      IDLE: begin
        sr_d  = '0;
        cnt_d = '0;
        if (can_pull) begin
          pull    = 1'b1;
          state_d = PRIME;
        end
      end

      PRIME: begin
        sr_d    = frame;
        cnt_d   = '0;
        state_d = RUN;
      end

      RUN: begin
        sr_d  = sr_q << 2;
        cnt_d = cnt_q + 4'd1;
        // Pull one cycle early so the word lands exactly on the frame boundary.
        if (cnt_q == CNT_PULL && can_pull) begin
          pull   = 1'b1;
          pend_d = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          pend_d = 1'b0;
          if (pend_q) begin
            sr_d = frame;
          end else if (i_tx_enable) begin
            // Zero frame keeps the 16-cycle cadence while the FIFO starves.
            sr_d       = '0;
            underrun_d = 1'b1;
          end else begin
            sr_d    = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase

    if (i_clear_underrun) underrun_d = 1'b0;
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_fifo_pull = pull && !i_reset;
  assign o_ddr_data  = sr_q[FRAME_BITS-1 -: 2];
  assign o_busy      = (state_q != IDLE);
  assign o_underrun  = underrun_q;

endmodule
